uart_cmd_fifo: RTL

Buffers bytes from the UART receiver and presents them to the CPU's memory-mapped UART data port as a zero-extended 32-bit word. It removes the one-byte handoff: edge-detects the receiver's `valid` level, queues each byte in a small FIFO, and pops one entry per CPU read. It also drives the 4-bit direction LEDs from the last accepted command byte. The block sits between the UART receiver and the RAM's `uart_data` input.

---
 rtl/uart_cmd_pkg.sv | 34 +++
 rtl/uart_cmd_fifo_byte_fifo.sv | 83 ++++++++
 rtl/uart_cmd_fifo.sv | 100 ++++++++++
 3 files changed

// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: command byte constants, direction LED codes and the
// byte-to-LED decode shared by the UART command FIFO.
package uart_cmd_pkg;

  localparam logic [7:0] CMD_UP    = 8'h55;  // 'U'
  localparam logic [7:0] CMD_DOWN  = 8'h44;  // 'D'
  localparam logic [7:0] CMD_LEFT  = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_RIGHT = 8'h52;  // 'R'

  localparam logic [3:0] LED_UP    = 4'b0001;
  localparam logic [3:0] LED_DOWN  = 4'b0010;
  localparam logic [3:0] LED_LEFT  = 4'b0100;
  localparam logic [3:0] LED_RIGHT = 4'b1000;
  localparam logic [3:0] LED_NONE  = 4'b0000;

  // One-hot LED code for a command byte; anything else lights nothing.
  function automatic logic [3:0] cmd_to_leds(input logic [7:0] b);
    logic [3:0] leds;
    case (b)
      CMD_UP:    leds = LED_UP;
      CMD_DOWN:  leds = LED_DOWN;
      CMD_LEFT:  leds = LED_LEFT;
      CMD_RIGHT: leds = LED_RIGHT;
      default:   leds = LED_NONE;
    endcase
    return leds;
  endfunction

  // True for one of the four recognised command bytes.
  function automatic logic is_cmd(input logic [7:0] b);
    return (cmd_to_leds(b) != LED_NONE);
  endfunction

endpackage

// File: rtl/uart_cmd_fifo_byte_fifo.sv
// byte_fifo: DEPTH x 8-bit show-ahead FIFO with registered count/full/empty.
// push and pop arrive already qualified by the wrapper: pop is never asserted
// when empty and push is never asserted when full without a same-cycle pop.
module byte_fifo
  import uart_cmd_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;

  // Next-state for pointers, occupancy and the registered full/empty flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == CW'(0));
  end

  // Control state; reset discards all entries at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage array; contents are don't-care while unoccupied, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = empty_q ? 8'h00 : mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/uart_cmd_fifo.sv
// uart_cmd_fifo: queues UART receiver bytes for the CPU data port, one push
// per rising edge of rx_valid, one pop per CPU read, sticky overflow flag
// and direction LEDs from the last accepted byte.
// Optional build macro UART_CMD_FILTER_EN: only the four command bytes are
// queued; every other byte is silently discarded.
module uart_cmd_fifo
  import uart_cmd_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  input  logic          rd_en,
  input  logic          clr_ovf,
  output logic [31:0]   rd_data,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic [3:0]    dir_leds
);

  logic       prev_valid_q, prev_valid_d;
  logic       overflow_q, overflow_d;
  logic [3:0] leds_q, leds_d;
  logic       cmd_ok_s;
  logic       push_req_s;
  logic       pop_s;
  logic       push_s;
  logic       drop_s;
  logic [7:0] fifo_rdata_s;
  logic       fifo_full_s;
  logic       fifo_empty_s;

`ifdef UART_CMD_FILTER_EN
  assign cmd_ok_s = is_cmd(rx_data);
`else
  assign cmd_ok_s = 1'b1;
`endif

  // Edge detect, push/pop qualification, overflow and LED next-state.
  always_comb begin
    prev_valid_d = rx_valid;
    push_req_s   = rx_valid & ~prev_valid_q & cmd_ok_s;
    pop_s        = rd_en & ~fifo_empty_s;
    // A full FIFO still takes a push when the same cycle frees a slot.
    push_s       = push_req_s & (~fifo_full_s | pop_s);
    drop_s       = push_req_s & fifo_full_s & ~pop_s;
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
    if (push_s) begin
      leds_d = cmd_to_leds(rx_data);
    end else begin
      leds_d = leds_q;
    end
  end

  // Wrapper state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      leds_q       <= LED_NONE;
    end else begin
      prev_valid_q <= prev_valid_d;
      overflow_q   <= overflow_d;
      leds_q       <= leds_d;
    end
  end

  byte_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (rx_data),
    .rdata (fifo_rdata_s),
    .count (count),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign rd_data  = {24'h000000, fifo_rdata_s};
  assign empty    = fifo_empty_s;
  assign full     = fifo_full_s;
  assign overflow = overflow_q;
  assign dir_leds = leds_q;

endmodule
